// File: rtl/mips_cpu_axi_master_if.sv
// AXI4-Lite bus between the CPU bus master and the address-decode fabric.
interface mips_cpu_axi_master_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/mips_cpu_axi_master.sv
// CPU load/store request to AXI4-Lite bridge, one transaction in flight,
// with wrapping read/write completion counters.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a new CPU request
// RD_AR   | read address presented, waiting for arready
// RD_R    | waiting for read data (rready high)
// RD_HOLD | load data presented to CPU until cpu_rdata_ready
// WR_AWW  | write address and data presented, each until its handshake
// WR_B    | waiting for write response (bready high)
module mips_cpu_axi_master #(
  parameter bit WAIT_BRESP = 1'b1
) (
  input  logic                         mips_cpu_clk,
  input  logic                         mips_cpu_reset,
  input  logic [31:0]                  cpu_addr,
  input  logic                         cpu_mem_read,
  input  logic                         cpu_mem_write,
  input  logic [31:0]                  cpu_wdata,
  input  logic [3:0]                   cpu_wstrb,
  output logic                         cpu_req_ready,
  output logic [31:0]                  cpu_rdata,
  output logic                         cpu_rdata_valid,
  input  logic                         cpu_rdata_ready,
  output logic                         cpu_wr_done,
  output logic                         bus_err,
  output logic [31:0]                  rd_cnt,
  output logic [31:0]                  wr_cnt,
  mips_cpu_axi_master_if.master        mips_cpu_axi_if
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, RD_HOLD, WR_AWW, WR_B} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;
  logic   aw_done_nxt;
  logic   w_done_nxt;
  logic   unused_addr_lsbs;

  // Byte-lane bits are dropped: the bus is word addressed.
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  // Request acceptance is a pure decode of the state register.
  assign cpu_req_ready = (state == IDLE);

  // Same-cycle view of write-channel progress, so completion can be seen
  // on the edge of the last handshake.
  assign aw_hs       = mips_cpu_axi_if.awvalid & mips_cpu_axi_if.awready;
  assign w_hs        = mips_cpu_axi_if.wvalid & mips_cpu_axi_if.wready;
  assign aw_done_nxt = aw_done | aw_hs;
  assign w_done_nxt  = w_done | w_hs;

  // Transaction FSM with all bus and CPU outputs registered.
  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) begin
      state                   <= IDLE;
      aw_done                 <= 1'b0;
      w_done                  <= 1'b0;
      mips_cpu_axi_if.araddr  <= '0;
      mips_cpu_axi_if.arvalid <= 1'b0;
      mips_cpu_axi_if.rready  <= 1'b0;
      mips_cpu_axi_if.awaddr  <= '0;
      mips_cpu_axi_if.awvalid <= 1'b0;
      mips_cpu_axi_if.wdata   <= '0;
      mips_cpu_axi_if.wstrb   <= '0;
      mips_cpu_axi_if.wvalid  <= 1'b0;
      mips_cpu_axi_if.bready  <= 1'b0;
      cpu_rdata               <= '0;
      cpu_rdata_valid         <= 1'b0;
      cpu_wr_done             <= 1'b0;
      bus_err                 <= 1'b0;
      rd_cnt                  <= '0;
      wr_cnt                  <= '0;
    end else begin
      cpu_wr_done <= 1'b0;
      // Without response tracking the B channel is simply drained forever.
      if (!WAIT_BRESP) mips_cpu_axi_if.bready <= 1'b1;

      case (state)
        IDLE: begin
          // A write takes priority; a simultaneous read is dropped.
          if (cpu_mem_write) begin
            mips_cpu_axi_if.awaddr  <= {cpu_addr[31:2], 2'b00};
            mips_cpu_axi_if.wdata   <= cpu_wdata;
            mips_cpu_axi_if.wstrb   <= cpu_wstrb;
            mips_cpu_axi_if.awvalid <= 1'b1;
            mips_cpu_axi_if.wvalid  <= 1'b1;
            aw_done                 <= 1'b0;
            w_done                  <= 1'b0;
            state                   <= WR_AWW;
          end else if (cpu_mem_read) begin
            mips_cpu_axi_if.araddr  <= {cpu_addr[31:2], 2'b00};
            mips_cpu_axi_if.arvalid <= 1'b1;
            state                   <= RD_AR;
          end
        end
        RD_AR: begin
          if (mips_cpu_axi_if.arready) begin
            mips_cpu_axi_if.arvalid <= 1'b0;
            mips_cpu_axi_if.rready  <= 1'b1;
            state                   <= RD_R;
          end
        end
        RD_R: begin
          if (mips_cpu_axi_if.rvalid) begin
            mips_cpu_axi_if.rready <= 1'b0;
            cpu_rdata              <= mips_cpu_axi_if.rdata;
            cpu_rdata_valid        <= 1'b1;
            rd_cnt                 <= rd_cnt + 32'd1;
            if (mips_cpu_axi_if.rresp != 2'b00) bus_err <= 1'b1;
            state                  <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (cpu_rdata_ready) begin
            cpu_rdata_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        WR_AWW: begin
          aw_done <= aw_done_nxt;
          w_done  <= w_done_nxt;
          if (aw_hs) mips_cpu_axi_if.awvalid <= 1'b0;
          if (w_hs)  mips_cpu_axi_if.wvalid  <= 1'b0;
          if (aw_done_nxt && w_done_nxt) begin
            if (WAIT_BRESP) begin
              mips_cpu_axi_if.bready <= 1'b1;
              state                  <= WR_B;
            end else begin
              cpu_wr_done <= 1'b1;
              wr_cnt      <= wr_cnt + 32'd1;
              state       <= IDLE;
            end
          end
        end
        WR_B: begin
          if (mips_cpu_axi_if.bvalid) begin
            mips_cpu_axi_if.bready <= 1'b0;
            cpu_wr_done            <= 1'b1;
            wr_cnt                 <= wr_cnt + 32'd1;
            if (mips_cpu_axi_if.bresp != 2'b00) bus_err <= 1'b1;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_axi_master.sv
// Bench for the CPU AXI4-Lite master: one instance waiting for B, one not.
module tb_mips_cpu_axi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_exp_t;

  logic [31:0] rd_q[$];
  wr_exp_t     wr_q[$];

  // instance with write-response tracking
  logic [31:0] c1_addr, c1_wdata, c1_rdata, c1_rd_cnt, c1_wr_cnt;
  logic [3:0]  c1_wstrb;
  logic        c1_rd, c1_wr, c1_req_ready, c1_rdata_valid, c1_rdata_ready;
  logic        c1_wr_done, c1_bus_err;
  mips_cpu_axi_master_if ax1 ();

  // instance completing writes on AW/W handshakes
  logic [31:0] c0_addr, c0_wdata, c0_rdata, c0_rd_cnt, c0_wr_cnt;
  logic [3:0]  c0_wstrb;
  logic        c0_rd, c0_wr, c0_req_ready, c0_rdata_valid, c0_rdata_ready;
  logic        c0_wr_done, c0_bus_err;
  mips_cpu_axi_master_if ax0 ();

  mips_cpu_axi_master #(.WAIT_BRESP(1'b1)) dut1 (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst),
    .cpu_addr(c1_addr), .cpu_mem_read(c1_rd), .cpu_mem_write(c1_wr),
    .cpu_wdata(c1_wdata), .cpu_wstrb(c1_wstrb), .cpu_req_ready(c1_req_ready),
    .cpu_rdata(c1_rdata), .cpu_rdata_valid(c1_rdata_valid),
    .cpu_rdata_ready(c1_rdata_ready), .cpu_wr_done(c1_wr_done),
    .bus_err(c1_bus_err), .rd_cnt(c1_rd_cnt), .wr_cnt(c1_wr_cnt),
    .mips_cpu_axi_if(ax1.master)
  );

  mips_cpu_axi_master #(.WAIT_BRESP(1'b0)) dut0 (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst),
    .cpu_addr(c0_addr), .cpu_mem_read(c0_rd), .cpu_mem_write(c0_wr),
    .cpu_wdata(c0_wdata), .cpu_wstrb(c0_wstrb), .cpu_req_ready(c0_req_ready),
    .cpu_rdata(c0_rdata), .cpu_rdata_valid(c0_rdata_valid),
    .cpu_rdata_ready(c0_rdata_ready), .cpu_wr_done(c0_wr_done),
    .bus_err(c0_bus_err), .rd_cnt(c0_rd_cnt), .wr_cnt(c0_wr_cnt),
    .mips_cpu_axi_if(ax0.master)
  );

  // reference state of dut1
  logic [31:0] rd_exp1 = 0, wr_exp1 = 0, wr_exp0 = 0;
  logic        err_exp1 = 1'b0;

  int wr_pulses1 = 0;
  int arv_seen1  = 0;

  // count write-done pulses and any read address activity on dut1
  always @(posedge clk) begin
    if (c1_wr_done) wr_pulses1++;
    if (ax1.arvalid) arv_seen1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                        input int ar_at, input int r_at, input int hold);
    bit ar_ok = 0;
    bit got   = 0;
    chk("rd_req_ready", c1_req_ready, 1'b1);
    c1_addr = a; c1_rd = 1'b1;
    rd_q.push_back(d);
    step();
    c1_rd = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (c1_rdata_valid) begin
        got = 1;
        chk("rd_latency", k, r_at + 1);
        if (rd_q.size() == 0) chk("rd_sb_empty", 0, 1);
        else chk("rd_data", c1_rdata, rd_q.pop_front());
        break;
      end
      chk("arvalid", ax1.arvalid, !ar_ok);
      if (!ar_ok) chk("araddr", ax1.araddr, {a[31:2], 2'b00});
      chk("rready", ax1.rready, ar_ok);
      ax1.arready = (k == ar_at);
      ax1.rvalid  = (k == r_at);
      ax1.rdata   = d;
      ax1.rresp   = resp;
      step();
      if (k == ar_at) ar_ok = 1;
    end
    ax1.arready = 1'b0; ax1.rvalid = 1'b0; ax1.rdata = '0; ax1.rresp = '0;
    if (!got) chk("rd_timeout", 0, 1);
    rd_exp1 = rd_exp1 + 1;
    if (resp != 2'b00) err_exp1 = 1'b1;
    for (int h = 0; h < hold; h++) begin
      chk("rd_hold_valid", c1_rdata_valid, 1'b1);
      chk("rd_hold_busy", c1_req_ready, 1'b0);
      step();
    end
    c1_rdata_ready = 1'b1;
    chk("rd_valid_pre", c1_rdata_valid, 1'b1);
    step();
    c1_rdata_ready = 1'b0;
    chk("rd_valid_post", c1_rdata_valid, 1'b0);
    chk("rd_idle", c1_req_ready, 1'b1);
    chk("rd_cnt", c1_rd_cnt, rd_exp1);
    chk("rd_data_held", c1_rdata, d);
    chk("rd_bus_err", c1_bus_err, err_exp1);
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_at, input int w_at, input int b_at, input logic [1:0] br,
                        input logic both);
    bit aw_ok = 0, w_ok = 0, got = 0;
    int pulses0;
    wr_exp_t e;
    pulses0 = wr_pulses1;
    c1_addr = a; c1_wdata = d; c1_wstrb = s; c1_wr = 1'b1; c1_rd = both;
    wr_q.push_back('{a: {a[31:2], 2'b00}, d: d, s: s});
    step();
    c1_wr = 1'b0; c1_rd = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (c1_wr_done) begin
        got = 1;
        chk("wr_latency", k, b_at + 1);
        break;
      end
      if (k == 1) begin
        if (wr_q.size() == 0) chk("wr_sb_empty", 0, 1);
        else begin
          e = wr_q.pop_front();
          chk("awaddr", ax1.awaddr, e.a);
          chk("wdata", ax1.wdata, e.d);
          chk("wstrb", {28'd0, ax1.wstrb}, {28'd0, e.s});
        end
      end
      chk("awvalid", ax1.awvalid, !aw_ok);
      chk("wvalid", ax1.wvalid, !w_ok);
      chk("bready", ax1.bready, aw_ok && w_ok);
      ax1.awready = (k == aw_at);
      ax1.wready  = (k == w_at);
      ax1.bvalid  = (k == b_at);
      ax1.bresp   = br;
      step();
      if (k == aw_at) aw_ok = 1;
      if (k == w_at)  w_ok  = 1;
    end
    ax1.awready = 1'b0; ax1.wready = 1'b0; ax1.bvalid = 1'b0; ax1.bresp = '0;
    if (!got) chk("wr_timeout", 0, 1);
    wr_exp1 = wr_exp1 + 1;
    if (br != 2'b00) err_exp1 = 1'b1;
    chk("wr_idle", c1_req_ready, 1'b1);
    chk("wr_cnt", c1_wr_cnt, wr_exp1);
    step();
    chk("wr_done_low", c1_wr_done, 1'b0);
    chk("wr_pulses", wr_pulses1 - pulses0, 1);
  endtask

  task automatic wr0_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_at, input int w_at);
    bit got = 0;
    wr_exp_t e;
    int last;
    last = (aw_at > w_at) ? aw_at : w_at;
    c0_addr = a; c0_wdata = d; c0_wstrb = s; c0_wr = 1'b1;
    wr_q.push_back('{a: {a[31:2], 2'b00}, d: d, s: s});
    step();
    c0_wr = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      chk("w0_bready", ax0.bready, 1'b1);
      if (c0_wr_done) begin
        got = 1;
        chk("w0_latency", k, last + 1);
        break;
      end
      if (k == 1) begin
        if (wr_q.size() == 0) chk("w0_sb_empty", 0, 1);
        else begin
          e = wr_q.pop_front();
          chk("w0_awaddr", ax0.awaddr, e.a);
          chk("w0_wdata", ax0.wdata, e.d);
          chk("w0_wstrb", {28'd0, ax0.wstrb}, {28'd0, e.s});
        end
      end
      chk("w0_awvalid", ax0.awvalid, k <= aw_at);
      chk("w0_wvalid", ax0.wvalid, k <= w_at);
      ax0.awready = (k == aw_at);
      ax0.wready  = (k == w_at);
      step();
    end
    ax0.awready = 1'b0; ax0.wready = 1'b0;
    if (!got) chk("w0_timeout", 0, 1);
    wr_exp0 = wr_exp0 + 1;
    chk("w0_idle", c0_req_ready, 1'b1);
    chk("w0_cnt", c0_wr_cnt, wr_exp0);
    chk("w0_bus_err", c0_bus_err, 1'b0);
  endtask

  initial begin
    int arv0;
    logic [31:0] rd_before;
    wr_exp_t e;
    rst = 1'b1;
    c1_addr = '0; c1_wdata = '0; c1_wstrb = '0; c1_rd = 0; c1_wr = 0; c1_rdata_ready = 0;
    c0_addr = '0; c0_wdata = '0; c0_wstrb = '0; c0_rd = 0; c0_wr = 0; c0_rdata_ready = 0;
    ax1.arready = 0; ax1.rdata = '0; ax1.rresp = '0; ax1.rvalid = 0;
    ax1.awready = 0; ax1.wready = 0; ax1.bresp = '0; ax1.bvalid = 0;
    ax0.arready = 0; ax0.rdata = '0; ax0.rresp = '0; ax0.rvalid = 0;
    ax0.awready = 0; ax0.wready = 0; ax0.bresp = '0; ax0.bvalid = 0;
    step(); step();

    chk("rst_req_ready", c1_req_ready, 1'b1);
    chk("rst_arvalid", ax1.arvalid, 1'b0);
    chk("rst_awvalid", ax1.awvalid, 1'b0);
    chk("rst_wvalid", ax1.wvalid, 1'b0);
    chk("rst_rready", ax1.rready, 1'b0);
    chk("rst_bready", ax1.bready, 1'b0);
    chk("rst_bready0", ax0.bready, 1'b0);
    chk("rst_rvalid_cpu", c1_rdata_valid, 1'b0);
    chk("rst_araddr", ax1.araddr, 32'h0);
    chk("rst_awaddr", ax1.awaddr, 32'h0);
    chk("rst_rdata", c1_rdata, 32'h0);
    chk("rst_bus_err", c1_bus_err, 1'b0);
    chk("rst_rd_cnt", c1_rd_cnt, 32'h0);
    chk("rst_wr_cnt", c1_wr_cnt, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_bready0", ax0.bready, 1'b1);
    chk("idle_bready1", ax1.bready, 1'b0);

    // zero-wait read at an unaligned address
    rd_txn(32'h0000_0106, 32'hDEAD_BEEF, 2'b00, 1, 2, 0);
    // write with AW early, W late, B after
    wr_txn(32'h0000_0203, 32'h1234_5678, 4'b0011, 1, 4, 6, 2'b00, 1'b0);

    // read and write together: the write wins, the read is dropped
    arv0 = arv_seen1;
    rd_before = c1_rd_cnt;
    wr_txn(32'h0000_0040, 32'hA5A5_5A5A, 4'b1111, 1, 1, 2, 2'b00, 1'b1);
    step();
    chk("both_no_ar", arv_seen1 - arv0, 0);
    chk("both_arvalid", ax1.arvalid, 1'b0);
    chk("both_rd_cnt", c1_rd_cnt, rd_before);

    // W before AW
    wr_txn(32'h0000_0010, 32'hCAFE_F00D, 4'b1000, 3, 1, 5, 2'b00, 1'b0);

    // error response is sticky across a later OKAY read with a held consumer
    rd_txn(32'h0000_0080, 32'h1111_2222, 2'b10, 2, 4, 0);
    rd_txn(32'h0000_0084, 32'h3333_4444, 2'b00, 1, 2, 5);

    // fire-and-forget writes, B channel never driven
    wr0_txn(32'h0000_0300, 32'h0BAD_F00D, 4'b0101, 1, 1);
    wr0_txn(32'h0000_0307, 32'h7777_8888, 4'b1110, 2, 3);
    step();
    chk("w0_bready_idle", ax0.bready, 1'b1);

    // reset while stuck in WR_AWW
    c1_addr = 32'h0000_0500; c1_wdata = 32'h5555_AAAA; c1_wstrb = 4'b1111; c1_wr = 1'b1;
    wr_q.push_back('{a: 32'h0000_0500, d: 32'h5555_AAAA, s: 4'b1111});
    step();
    c1_wr = 1'b0;
    e = wr_q.pop_front();
    chk("rw_awaddr", ax1.awaddr, e.a);
    chk("rw_awvalid", ax1.awvalid, 1'b1);
    chk("rw_wvalid", ax1.wvalid, 1'b1);
    ax1.awready = 1'b1;
    step();
    ax1.awready = 1'b0;
    chk("rw_aw_drop", ax1.awvalid, 1'b0);
    chk("rw_w_hold", ax1.wvalid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_exp1 = 0; wr_exp1 = 0; err_exp1 = 1'b0;
    chk("rw_awvalid0", ax1.awvalid, 1'b0);
    chk("rw_wvalid0", ax1.wvalid, 1'b0);
    chk("rw_idle", c1_req_ready, 1'b1);
    chk("rw_rd_cnt", c1_rd_cnt, rd_exp1);
    chk("rw_wr_cnt", c1_wr_cnt, wr_exp1);
    chk("rw_bus_err", c1_bus_err, err_exp1);
    step();
    chk("rw_stay_idle", c1_req_ready, 1'b1);
    chk("rw_no_bready", ax1.bready, 1'b0);

    // bridge still usable after the abandoned write
    rd_txn(32'h0000_0010, 32'h0F0F_F0F0, 2'b00, 1, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
